// File: rtl/reg_dump_streamer.sv
// Register-file readout streamer: halts the CPU after a fixed cycle count or on
// request, then streams r0..r(NUM_REGS-1) as indexed beats over valid/ready.
module reg_dump_streamer #(
  parameter int NUM_REGS      = 13,
  parameter int DATA_W        = 32,
  parameter int IDX_W         = 5,
  parameter int TRIGGER_COUNT = 25
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dump_req_i,
  output logic [IDX_W-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              cpu_halt_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o
);

  localparam int CW = (TRIGGER_COUNT < 1) ? 1 : $clog2(TRIGGER_COUNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cyc_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_halt;
  logic                r_valid;
  logic [IDX_W-1:0]    r_dump_idx;
  logic [DATA_W-1:0]   r_dump_data;
  logic                r_done;
  logic                w_auto_hit;
  logic                w_last;

  // Compare in 32 bits so cyc_cnt+1 cannot wrap inside the narrow counter.
  assign w_auto_hit = (TRIGGER_COUNT != 0) &&
                      ((32'(r_cyc_cnt) + 32'd1) == 32'(TRIGGER_COUNT));
  assign w_last     = (r_idx == IDX_W'(NUM_REGS - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cyc_cnt   <= '0;
      r_idx       <= '0;
      r_halt      <= 1'b0;
      r_valid     <= 1'b0;
      r_dump_idx  <= '0;
      r_dump_data <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (32'(r_cyc_cnt) < 32'(TRIGGER_COUNT))
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          if (dump_req_i || w_auto_hit) begin
            r_state <= S_FETCH;
            r_idx   <= '0;
            r_halt  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_dump_data <= rf_rdata_i;
          r_dump_idx  <= r_idx;
          r_valid     <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (dump_ready_i) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (dump_req_i) begin
            r_state <= S_FETCH;
            r_idx   <= '0;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rf_raddr_o   = r_idx;
  assign cpu_halt_o   = r_halt;
  assign dump_valid_o = r_valid;
  assign dump_idx_o   = r_dump_idx;
  assign dump_data_o  = r_dump_data;
  assign done_o       = r_done;

endmodule
